// File: rtl/seq_divider.sv
// seq_divider: 4-bit unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_DEBUG_PORTS_EN to expose the live internal registers.
module seq_divider (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  output logic [3:0] q_out,
  output logic [3:0] r_out,
  output logic       busy,
  output logic       done,
  output logic       div_zero
`ifdef SEQ_DIVIDER_DEBUG_PORTS_EN
  ,
  output logic [4:0] rem,
  output logic [3:0] quo,
  output logic [3:0] div,
  output logic [1:0] cnt,
  output logic [1:0] state
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} st_t;
  st_t st, st_nx;
  logic [4:0] rem_r, sh, rem_nx;
  logic [3:0] quo_r, div_r, quo_nx;
  logic [1:0] cnt_r;
  logic       ge;
  always_ff @(posedge clk)
    st <= clr ? IDLE : st_nx;
  always_comb begin
    st_nx = st == IDLE ? (start ? (b_in == 4'd0 ? DONE : CALC) : IDLE) :
            st == CALC ? (cnt_r == 2'd3 ? DONE : CALC) : IDLE;
  end
  always_comb begin
    busy = st == CALC;
    done = st == DONE;
  end
  // Remainder stays below the divisor, so the shifted value always fits in 5 bits.
  always_comb begin
    sh     = {rem_r[3:0], quo_r[3]};
    ge     = sh >= {1'b0, div_r};
    rem_nx = ge ? sh - {1'b0, div_r} : sh;
    quo_nx = {quo_r[2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      rem_r    <= '0;
      quo_r    <= '0;
      div_r    <= '0;
      cnt_r    <= '0;
      q_out    <= '0;
      r_out    <= '0;
      div_zero <= 1'b0;
    end else if (st == IDLE && start) begin
      quo_r <= a_in;
      div_r <= b_in;
      rem_r <= '0;
      cnt_r <= '0;
      if (b_in == 4'd0) begin
        q_out    <= 4'hF;
        r_out    <= a_in;
        div_zero <= 1'b1;
      end
    end else if (st == CALC) begin
      rem_r <= rem_nx;
      quo_r <= quo_nx;
      cnt_r <= cnt_r + 2'd1;
      if (cnt_r == 2'd3) begin
        q_out    <= quo_nx;
        r_out    <= rem_nx[3:0];
        div_zero <= 1'b0;
      end
    end
  end
`ifdef SEQ_DIVIDER_DEBUG_PORTS_EN
  assign rem   = rem_r;
  assign quo   = quo_r;
  assign div   = div_r;
  assign cnt   = cnt_r;
  assign state = st;
`endif
endmodule
